// File: rtl/fifo_uart_tx_drain_if.sv
`default_nettype none
// ============================================================================
// Module  : fifo_uart_tx_drain_if
// Brief   : FIFO-side handshake and UART-side outputs of the FIFO-to-UART drain.
// Revision: 1.0 - initial release
// ============================================================================
interface fifo_uart_tx_drain_if #(
  parameter int CNT_W = 16
);
  logic             en;
  logic             fifo_empty;
  logic [7:0]       fifo_data;
  logic             fifo_pop;
  logic             tx;
  logic             busy;
  logic             tx_done;
  logic [CNT_W-1:0] sent_count;

  // master: the drain itself; slave: the FIFO / pin / control side
  modport master (
    input  en, fifo_empty, fifo_data,
    output fifo_pop, tx, busy, tx_done, sent_count
  );

  modport slave (
    output en, fifo_empty, fifo_data,
    input  fifo_pop, tx, busy, tx_done, sent_count
  );
endinterface
`default_nettype wire

// File: rtl/fifo_uart_tx_drain.sv
`default_nettype none
// ============================================================================
// Module  : fifo_uart_tx_drain
// Brief   : Pops bytes from a FIFO and serialises them as 8-bit UART frames.
// Revision: 1.0 - initial release
// ============================================================================
module fifo_uart_tx_drain #(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_EN    = 1'b0,
  parameter int CNT_W        = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  fifo_uart_tx_drain_if.master bus
);

  localparam int                BAUD_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_POP    = 3'd1,
    S_LOAD   = 3'd2,
    S_START  = 3'd3,
    S_DATA   = 3'd4,
    S_PARITY = 3'd5,
    S_STOP   = 3'd6
  } state_e;

  state_e            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic              pop_q, pop_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              bit_end;
  logic              start_next;

  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    par_d      = par_q;
    cnt_d      = cnt_q;
    bit_end    = (baud_q == BAUD_LAST);
    start_next = bus.en && !bus.fifo_empty;

    unique case (state_q)
      S_IDLE:   if (start_next) state_d = S_POP;
      S_POP:    state_d = S_LOAD;
      S_LOAD: begin
        shift_d = bus.fifo_data;
        par_d   = ^bus.fifo_data;
        state_d = S_START;
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d = PARITY_EN ? S_PARITY : S_STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end
      end
      S_PARITY: if (bit_end) state_d = S_STOP;
      S_STOP:   if (bit_end) state_d = start_next ? S_POP : S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Baud counter restarts on every state change and idles at zero.
    if ((state_d != state_q) || bit_end || (state_q == S_IDLE)) begin
      baud_d = '0;
    end else begin
      baud_d = baud_q + BAUD_W'(1);
    end

    // Outputs are decoded from the next state so they can be registered.
    pop_d  = (state_d == S_POP);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_STOP) && (baud_d == BAUD_LAST);
    if (done_d) cnt_d = cnt_q + CNT_W'(1);

    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      pop_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      pop_q   <= pop_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.tx         = tx_q;
  assign bus.fifo_pop   = pop_q;
  assign bus.busy       = busy_q;
  assign bus.tx_done    = done_q;
  assign bus.sent_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx_drain.sv
`default_nettype none
// ============================================================================
// Module  : tb_fifo_uart_tx_drain
// Brief   : Drives a FIFO model into two drains (no parity / even parity) and
//           decodes their tx lines against the pushed byte stream.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fifo_uart_tx_drain;

  localparam int CPB   = 4;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic en    = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   phase   = 0;
  int   wr_ptr  = 0;

  logic [7:0] fmem    [0:255];
  logic [7:0] sb_byte [0:255];
  bit         sb_skip [0:255];

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int pos, input bit par_en);
    if (pos == 0) return 1'b0;
    if (pos <= 8) return b[pos-1];
    if (pos == 9 && par_en) return ^b;
    return 1'b1;
  endfunction

  for (genvar P = 0; P < 2; P++) begin : g_inst
    localparam int LAST = (10 + P) * CPB - 1;

    fifo_uart_tx_drain_if #(.CNT_W(CNT_W)) bus ();

    int         rd_ptr = 0;
    logic [7:0] fdata  = 8'h00;
    logic       en_e    = 1'b0;
    logic       empty_e = 1'b1;

    assign bus.en         = en;
    assign bus.fifo_empty = (rd_ptr == wr_ptr);
    assign bus.fifo_data  = fdata;

    fifo_uart_tx_drain #(
      .CLKS_PER_BIT (CPB),
      .PARITY_EN    (P == 1),
      .CNT_W        (CNT_W)
    ) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
    );

    // FIFO model: data valid the cycle after pop, garbage otherwise.
    always @(posedge clk) begin
      en_e    <= en;
      empty_e <= bus.fifo_empty;
      if (bus.fifo_pop && rd_ptr != wr_ptr) begin
        fdata  <= fmem[rd_ptr];
        rd_ptr <= rd_ptr + 1;
      end else begin
        fdata <= 8'($urandom);
      end
    end

    int         cyc = 0, k = 0, frames = 0, errs = 0, sb_rd = 0;
    int         pop_cyc = -100, end_cyc = -100;
    bit         in_frame = 1'b0;
    logic [7:0] exp_b = 8'h00, rx_b = 8'h00;

    always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
        in_frame = 1'b0;
        frames   = 0;
      end else begin
        if (bus.fifo_pop) begin
          chk($sformatf("pop_legal_p%0d {en,empty}", P), {en_e, empty_e}, 2'b10);
          pop_cyc = cyc;
        end
        if (phase == 1) begin
          chk($sformatf("idle_tx_p%0d", P), bus.tx, 1);
          chk($sformatf("idle_pop_p%0d", P), bus.fifo_pop, 0);
          chk($sformatf("idle_busy_p%0d", P), bus.busy, 0);
          chk($sformatf("idle_count_p%0d", P), bus.sent_count, 0);
        end
        if (!in_frame) begin
          if (bus.tx_done) chk($sformatf("done_outside_frame_p%0d", P), 1, 0);
          if (bus.tx == 1'b0) begin
            in_frame = 1'b1;
            k        = 0;
            errs     = 0;
            rx_b     = 8'h00;
            chk($sformatf("pop_to_start_p%0d", P), cyc - pop_cyc, 2);
            if (frames > 0 && pop_cyc == end_cyc + 1)
              chk($sformatf("b2b_gap_p%0d", P), cyc - end_cyc - 1, 2);
            while (sb_rd < wr_ptr && sb_skip[sb_rd]) sb_rd++;
            if (sb_rd < wr_ptr) begin
              exp_b = sb_byte[sb_rd];
              sb_rd++;
            end else begin
              chk($sformatf("sb_has_byte_p%0d", P), 0, 1);
              exp_b = 8'h00;
            end
          end
        end
        if (in_frame) begin
          if (bus.tx !== frame_bit(exp_b, k / CPB, P == 1)) errs++;
          if (bus.tx_done !== (k == LAST)) errs++;
          if (bus.busy !== 1'b1) errs++;
          if (k / CPB >= 1 && k / CPB <= 8 && k % CPB == CPB / 2) rx_b[k/CPB-1] = bus.tx;
          if (k == LAST) begin
            chk($sformatf("frame_bits_p%0d byte %0h", P, exp_b), errs, 0);
            chk($sformatf("rx_byte_p%0d", P), rx_b, exp_b);
            chk($sformatf("count_at_done_p%0d", P), bus.sent_count, frames + 1);
            frames++;
            in_frame = 1'b0;
            end_cyc  = cyc;
          end
          k++;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    if (wr_ptr < 256) begin
      fmem[wr_ptr]    = b;
      sb_byte[wr_ptr] = b;
      sb_skip[wr_ptr] = 1'b0;
      wr_ptr++;
    end
  endtask

  task automatic drain(input int budget);
    int t = 0;
    while (t < budget && !(g_inst[0].rd_ptr == wr_ptr && g_inst[1].rd_ptr == wr_ptr &&
                           !g_inst[0].bus.busy && !g_inst[1].bus.busy)) begin
      tick();
      t++;
    end
    chk("drain_timeout", t >= budget, 0);
    repeat (4) tick();
  endtask

  task automatic check_counts(input int exp_frames);
    chk("sent_count_p0", g_inst[0].bus.sent_count, exp_frames);
    chk("sent_count_p1", g_inst[1].bus.sent_count, exp_frames);
    chk("frames_p0", g_inst[0].frames, exp_frames);
    chk("frames_p1", g_inst[1].frames, exp_frames);
    chk("busy_after_p0", g_inst[0].bus.busy, 0);
    chk("busy_after_p1", g_inst[1].bus.busy, 0);
  endtask

  initial begin
    int exp_frames;
    repeat (3) tick();
    chk("rst_tx_p0", g_inst[0].bus.tx, 1);
    chk("rst_tx_p1", g_inst[1].bus.tx, 1);
    chk("rst_pop_p0", g_inst[0].bus.fifo_pop, 0);
    chk("rst_busy_p1", g_inst[1].bus.busy, 0);
    chk("rst_done_p0", g_inst[0].bus.tx_done, 0);
    chk("rst_count_p1", g_inst[1].bus.sent_count, 0);
    rst_n = 1'b1;
    phase = 1;
    repeat (50) tick();
    phase = 0;

    push(8'h55);
    drain(300);
    check_counts(1);

    push(8'h55);
    push(8'h07);
    drain(300);
    check_counts(3);

    for (int i = 1; i <= 8; i++) push(8'(i));
    drain(1000);
    check_counts(11);

    // en dropped while 0xA3 is in its data bits
    push(8'hA3);
    push(8'h5C);
    repeat (12) tick();
    en = 1'b0;
    repeat (80) tick();
    check_counts(12);
    chk("held_byte_p0", g_inst[0].rd_ptr, wr_ptr - 1);
    chk("held_byte_p1", g_inst[1].rd_ptr, wr_ptr - 1);
    en = 1'b1;
    drain(300);
    check_counts(13);

    exp_frames = 13;
    repeat (600) begin
      tick();
      if ($urandom_range(0, 15) == 0) begin
        push(8'($urandom));
        exp_frames++;
      end
      if ($urandom_range(0, 19) == 0) en = ~en;
    end
    en = 1'b1;
    drain(4000);
    check_counts(exp_frames);

    // reset in the middle of 0xC6; 0x3B must follow cleanly
    push(8'hC6);
    push(8'h3B);
    repeat (12) tick();
    rst_n = 1'b0;
    #1;
    chk("async_rst_tx_p0", g_inst[0].bus.tx, 1);
    chk("async_rst_tx_p1", g_inst[1].bus.tx, 1);
    chk("async_rst_busy_p0", g_inst[0].bus.busy, 0);
    chk("async_rst_busy_p1", g_inst[1].bus.busy, 0);
    sb_skip[wr_ptr-2] = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    drain(300);
    check_counts(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
